// File: rtl/cis_dvp_capture.sv
// DVP camera capture front end: oversampled sensor pins, frame/line tracking, pixel FIFO
// and valid/ready pixel stream. Define CIS_CROP_EN to add the crop-window inputs.
module cis_dvp_capture #(
    parameter int DATA_W     = 10,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 12
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cis_pclk_i,
    input  logic              cis_href_i,
    input  logic              cis_vsync_i,
    input  logic [DATA_W-1:0] cis_data_i,
    input  logic              enable_i,
    input  logic              ovf_clr_i,
`ifdef CIS_CROP_EN
    input  logic [CNT_W-1:0]  crop_x0_i,
    input  logic [CNT_W-1:0]  crop_y0_i,
    input  logic [CNT_W-1:0]  crop_w_i,
    input  logic [CNT_W-1:0]  crop_h_i,
`endif
    output logic              pix_valid_o,
    input  logic              pix_ready_i,
    output logic [DATA_W-1:0] pix_data_o,
    output logic              pix_sof_o,
    output logic              pix_sol_o,
    output logic [CNT_W-1:0]  line_len_o,
    output logic [15:0]       frame_cnt_o,
    output logic              frame_done_o,
    output logic              ovf_o,
    output logic              busy_o
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] L_DEPTH = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_FRAME,
        ST_DROP
    } state_t;

    typedef struct packed {
        logic              sof;
        logic              sol;
        logic [DATA_W-1:0] data;
    } pix_t;

    // ---------------------------------------------------------------- pin sync
    logic              r_pclk_s1, r_pclk_s2, r_pclk_s3;
    logic              r_href_s1, r_href_s2, r_href_s3;
    logic              r_vsync_s1, r_vsync_s2, r_vsync_s3;
    logic [DATA_W-1:0] r_data_s1, r_data_s2;

    // NOTE: every clocked register uses <= so all flops sample the pre-edge values;
    // a blocking = here would collapse the s1/s2/s3 chain into a single stage.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_pclk_s1  <= 1'b0;
            r_pclk_s2  <= 1'b0;
            r_pclk_s3  <= 1'b0;
            r_href_s1  <= 1'b0;
            r_href_s2  <= 1'b0;
            r_href_s3  <= 1'b0;
            r_vsync_s1 <= 1'b0;
            r_vsync_s2 <= 1'b0;
            r_vsync_s3 <= 1'b0;
            r_data_s1  <= '0;
            r_data_s2  <= '0;
        end else begin
            r_pclk_s1  <= cis_pclk_i;
            r_pclk_s2  <= r_pclk_s1;
            r_pclk_s3  <= r_pclk_s2;
            r_href_s1  <= cis_href_i;
            r_href_s2  <= r_href_s1;
            r_href_s3  <= r_href_s2;
            r_vsync_s1 <= cis_vsync_i;
            r_vsync_s2 <= r_vsync_s1;
            r_vsync_s3 <= r_vsync_s2;
            r_data_s1  <= cis_data_i;
            r_data_s2  <= r_data_s1;
        end
    end

    logic w_pclk_rise, w_href_fall, w_vsync_rise, w_capture;

    assign w_pclk_rise  = r_pclk_s2 & ~r_pclk_s3;
    assign w_href_fall  = ~r_href_s2 & r_href_s3;
    assign w_vsync_rise = r_vsync_s2 & ~r_vsync_s3;
    assign w_capture    = w_pclk_rise & r_href_s2;

    // ---------------------------------------------------------------- control state
    state_t           r_state;
    logic [CNT_W-1:0] r_x, r_y;
    logic [CNT_W-1:0] r_line_len;
    logic [15:0]      r_frame_cnt;
    logic             r_frame_done;
    logic             r_sof_pend, r_sol_pend;
    logic             r_ovf;
    logic             w_in_win;

`ifdef CIS_CROP_EN
    logic [CNT_W-1:0] r_crop_x0, r_crop_y0, r_crop_w, r_crop_h;
    logic [CNT_W:0]   w_x_end, w_y_end;

    // One extra bit keeps x0+w from wrapping back into the window.
    assign w_x_end  = {1'b0, r_crop_x0} + {1'b0, r_crop_w};
    assign w_y_end  = {1'b0, r_crop_y0} + {1'b0, r_crop_h};
    assign w_in_win = (r_x >= r_crop_x0) && ({1'b0, r_x} < w_x_end) &&
                      (r_y >= r_crop_y0) && ({1'b0, r_y} < w_y_end);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_crop_x0 <= '0;
            r_crop_y0 <= '0;
            r_crop_w  <= '0;
            r_crop_h  <= '0;
        end else if (w_vsync_rise) begin
            r_crop_x0 <= crop_x0_i;
            r_crop_y0 <= crop_y0_i;
            r_crop_w  <= crop_w_i;
            r_crop_h  <= crop_h_i;
        end
    end
`else
    assign w_in_win = 1'b1;
`endif

    // ---------------------------------------------------------------- FIFO flags
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_cnt;
    logic [AW:0]   w_occ;
    logic          r_out_valid;
    pix_t          r_out_pix;
    pix_t          w_wr_pix;
    logic          w_pop, w_load, w_full, w_wr_req, w_wr_en, w_ovf_evt;

    // Occupancy includes the output register so the stream sees exactly FIFO_DEPTH entries.
    assign w_occ     = r_cnt + {{AW{1'b0}}, r_out_valid};
    assign w_full    = (w_occ == L_DEPTH);
    assign w_pop     = r_out_valid & pix_ready_i;
    assign w_load    = (r_cnt != '0) & (~r_out_valid | pix_ready_i);
    assign w_wr_req  = (r_state == ST_FRAME) & w_capture & w_in_win;
    assign w_wr_en   = w_wr_req & (~w_full | w_pop);
    assign w_ovf_evt = w_wr_req & w_full & ~w_pop;
    assign w_wr_pix  = {r_sof_pend, r_sol_pend, r_data_s2};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state      <= ST_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_line_len   <= '0;
            r_frame_cnt  <= '0;
            r_frame_done <= 1'b0;
            r_sof_pend   <= 1'b0;
            r_sol_pend   <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            if (w_ovf_evt)
                r_ovf <= 1'b1;
            else if (ovf_clr_i)
                r_ovf <= 1'b0;

            if (w_wr_en) begin
                r_sof_pend <= 1'b0;
                r_sol_pend <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (enable_i)
                        r_state <= ST_SYNC;
                end

                ST_SYNC: begin
                    if (!enable_i) begin
                        r_state <= ST_IDLE;
                    end else if (w_vsync_rise) begin
                        r_state    <= ST_FRAME;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_sof_pend <= 1'b1;
                        r_sol_pend <= 1'b1;
                    end
                end

                ST_FRAME: begin
                    if (w_capture && (r_x != '1))
                        r_x <= r_x + 1'b1;

                    if (w_href_fall) begin
                        r_line_len <= r_x;
                        r_x        <= '0;
                        r_sol_pend <= 1'b1;
                        if (r_y != '1)
                            r_y <= r_y + 1'b1;
                    end

                    if (w_vsync_rise) begin
                        r_frame_cnt  <= r_frame_cnt + 1'b1;
                        r_frame_done <= 1'b1;
                        r_x          <= '0;
                        r_y          <= '0;
                        r_sof_pend   <= 1'b1;
                        r_sol_pend   <= 1'b1;
                        r_state      <= enable_i ? ST_FRAME : ST_IDLE;
                    end else if (w_ovf_evt) begin
                        r_state <= ST_DROP;
                    end
                end

                ST_DROP: begin
                    // The frame that overflowed is abandoned, so its end is not counted.
                    if (w_vsync_rise) begin
                        r_x        <= '0;
                        r_y        <= '0;
                        r_sof_pend <= 1'b1;
                        r_sol_pend <= 1'b1;
                        r_state    <= enable_i ? ST_FRAME : ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- FIFO storage
    pix_t r_mem [FIFO_DEPTH];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr_en)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_load)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_load})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers and counts define
    // which entries are live, and a reset-free array maps onto plain RAM.
    always_ff @(posedge wb_clk_i) begin
        if (w_wr_en)
            r_mem[r_wr_ptr] <= w_wr_pix;
    end

    // Output register holds valid/data/tags stable until the consumer accepts them.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_out_valid <= 1'b0;
            r_out_pix   <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_pix   <= r_mem[r_rd_ptr];
        end else if (w_pop) begin
            r_out_valid <= 1'b0;
        end
    end

    assign pix_valid_o  = r_out_valid;
    assign pix_data_o   = r_out_pix.data;
    assign pix_sof_o    = r_out_pix.sof;
    assign pix_sol_o    = r_out_pix.sol;
    assign line_len_o   = r_line_len;
    assign frame_cnt_o  = r_frame_cnt;
    assign frame_done_o = r_frame_done;
    assign ovf_o        = r_ovf;
    assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cis_dvp_capture.sv
// Directed bench for cis_dvp_capture: framing, overflow recovery, disable, reset and latency.
// Crop-window steps are compiled in only when CIS_CROP_EN is defined.
module tb_cis_dvp_capture;

    localparam int DATA_W     = 10;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              pclk, href, vsync;
    logic [DATA_W-1:0] data;
    logic              enable, ovf_clr, pix_ready;
    logic              pix_valid, pix_sof, pix_sol, frame_done, ovf, busy;
    logic [DATA_W-1:0] pix_data;
    logic [CNT_W-1:0]  line_len;
    logic [15:0]       frame_cnt;
`ifdef CIS_CROP_EN
    logic [CNT_W-1:0]  crop_x0, crop_y0, crop_w, crop_h;
`endif

    cis_dvp_capture #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .cis_pclk_i   (pclk),
        .cis_href_i   (href),
        .cis_vsync_i  (vsync),
        .cis_data_i   (data),
        .enable_i     (enable),
        .ovf_clr_i    (ovf_clr),
`ifdef CIS_CROP_EN
        .crop_x0_i    (crop_x0),
        .crop_y0_i    (crop_y0),
        .crop_w_i     (crop_w),
        .crop_h_i     (crop_h),
`endif
        .pix_valid_o  (pix_valid),
        .pix_ready_i  (pix_ready),
        .pix_data_o   (pix_data),
        .pix_sof_o    (pix_sof),
        .pix_sol_o    (pix_sol),
        .line_len_o   (line_len),
        .frame_cnt_o  (frame_cnt),
        .frame_done_o (frame_done),
        .ovf_o        (ovf),
        .busy_o       (busy)
    );

    int n_checks    = 0;
    int n_errors    = 0;
    int done_pulses = 0;
    int d0;

    logic [DATA_W+1:0] q[$];      // observed {sof, sol, data}
    logic [DATA_W+1:0] exp_q[$];  // expected {sof, sol, data}

    // Transfers and frame_done pulses are sampled on the falling edge.
    always @(negedge clk) begin
        if (pix_valid && pix_ready)
            q.push_back({pix_sof, pix_sol, pix_data});
        if (frame_done)
            done_pulses++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One sensor pixel clock = 4 system clocks; data/href change while pclk is low.
    task automatic pclk_cycle(input logic href_v, input logic [DATA_W-1:0] d);
        href = href_v;
        data = d;
        pclk = 1'b0;
        step(2);
        pclk = 1'b1;
        step(2);
    endtask

    task automatic send_line(input int base);
        for (int i = 0; i < 8; i++)
            pclk_cycle(1'b1, DATA_W'(base + i));
        pclk_cycle(1'b0, '0);
        pclk_cycle(1'b0, '0);
    endtask

    task automatic send_frame(input int base);
        for (int l = 0; l < 4; l++)
            send_line(base + 8 * l);
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        pclk_cycle(1'b0, '0);
        pclk_cycle(1'b0, '0);
        vsync = 1'b0;
        pclk_cycle(1'b0, '0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    function automatic logic [DATA_W+1:0] mk(input logic sof, input logic sol, input int d);
        return {sof, sol, DATA_W'(d)};
    endfunction

    task automatic add_frame_exp(input int base, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(mk(i == 0, (i % 8) == 0, base + i));
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_count"}, 32'(q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < q.size(); i++)
            check($sformatf("%s_pix%0d", tag, i), 32'(q[i]), 32'(exp_q[i]));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},     32'(pix_valid),  32'd0);
        check({tag, "_data"},      32'(pix_data),   32'd0);
        check({tag, "_sof"},       32'(pix_sof),    32'd0);
        check({tag, "_sol"},       32'(pix_sol),    32'd0);
        check({tag, "_line_len"},  32'(line_len),   32'd0);
        check({tag, "_frame_cnt"}, 32'(frame_cnt),  32'd0);
        check({tag, "_done"},      32'(frame_done), 32'd0);
        check({tag, "_ovf"},       32'(ovf),        32'd0);
        check({tag, "_busy"},      32'(busy),       32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        pclk      = 1'b0;
        href      = 1'b0;
        vsync     = 1'b0;
        data      = '0;
        enable    = 1'b0;
        ovf_clr   = 1'b0;
        pix_ready = 1'b0;
`ifdef CIS_CROP_EN
        crop_x0   = '0;
        crop_y0   = '0;
        crop_w    = '0;
        crop_h    = '0;
`endif

        // ---- reset values
        step(3);
        check_all_zero("reset");
        rst = 1'b0;
        step(1);

        // ---- two clean 4x8 frames with ready held high
        enable    = 1'b1;
        pix_ready = 1'b1;
        step(1);
        check("t1_busy_after_enable", 32'(busy), 32'd1);
        d0 = done_pulses;
        vsync_pulse();
        send_frame(32'h100);
        vsync_pulse();
        send_frame(32'h200);
        vsync_pulse();
        step(8);
        check("t1_frame_cnt", 32'(frame_cnt), 32'd2);
        check("t1_line_len", 32'(line_len), 32'd8);
        check("t1_done_pulses", 32'(done_pulses - d0), 32'd2);
        check("t1_ovf", 32'(ovf), 32'd0);
        add_frame_exp(32'h100, 32);
        add_frame_exp(32'h200, 32);
        check_stream("t1");

        // ---- overflow: consumer stalled for all of frame 1
        reset_dut();
        q.delete();
        exp_q.delete();
        pix_ready = 1'b0;
        enable    = 1'b1;
        d0        = done_pulses;
        vsync_pulse();
        send_frame(32'h100);
        step(2);
        check("t2_ovf_set", 32'(ovf), 32'd1);
        check("t2_busy_in_drop", 32'(busy), 32'd1);
        check("t2_head_valid", 32'(pix_valid), 32'd1);
        check("t2_head_data", 32'(pix_data), 32'h100);
        check("t2_head_sof", 32'(pix_sof), 32'd1);
        pix_ready = 1'b1;
        vsync_pulse();
        check("t2_drop_vsync_not_counted", 32'(frame_cnt), 32'd0);
        check("t2_drop_vsync_no_done", 32'(done_pulses - d0), 32'd0);
        send_frame(32'h200);
        vsync_pulse();
        step(8);
        check("t2_frame_cnt", 32'(frame_cnt), 32'd1);
        check("t2_done_pulses", 32'(done_pulses - d0), 32'd1);
        add_frame_exp(32'h100, FIFO_DEPTH);
        add_frame_exp(32'h200, 32);
        check_stream("t2");

        // ---- overflow clear with no new overflow
        check("t3_ovf_before_clear", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("t3_ovf_cleared", 32'(ovf), 32'd0);

        // ---- disable in the middle of frame 1
        reset_dut();
        q.delete();
        exp_q.delete();
        pix_ready = 1'b1;
        enable    = 1'b1;
        d0        = done_pulses;
        vsync_pulse();
        send_line(32'h100);
        send_line(32'h108);
        enable = 1'b0;
        send_line(32'h110);
        send_line(32'h118);
        check("t4_busy_completing", 32'(busy), 32'd1);
        vsync_pulse();
        check("t4_busy_after_vsync", 32'(busy), 32'd0);
        check("t4_frame_cnt_after_f1", 32'(frame_cnt), 32'd1);
        send_frame(32'h200);
        vsync_pulse();
        step(8);
        check("t4_frame_cnt_final", 32'(frame_cnt), 32'd1);
        check("t4_done_pulses", 32'(done_pulses - d0), 32'd1);
        check("t4_line_len", 32'(line_len), 32'd8);
        add_frame_exp(32'h100, 32);
        check_stream("t4");

        // ---- reset in the middle of a line with pixels queued
        q.delete();
        exp_q.delete();
        pix_ready = 1'b0;
        enable    = 1'b1;
        vsync_pulse();
        pclk_cycle(1'b1, 10'h155);
        pclk_cycle(1'b1, 10'h156);
        pclk_cycle(1'b1, 10'h157);
        step(4);
        check("t5_valid_before_rst", 32'(pix_valid), 32'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_all_zero("t5_rst");
        pix_ready = 1'b1;
        send_line(32'h160);
        check("t5_no_stray_count", 32'(q.size()), 32'd0);
        check("t5_no_stray_valid", 32'(pix_valid), 32'd0);
        check("t5_busy_sync", 32'(busy), 32'd1);
        vsync_pulse();

        // ---- pin-to-stream latency: 3 cycles to FIFO write, 1 more to valid
        href = 1'b1;
        data = 10'h3AB;
        pclk = 1'b0;
        step(2);
        pclk = 1'b1;
        step(3);
        check("t5_latency_not_yet", 32'(pix_valid), 32'd0);
        step(1);
        check("t5_latency_valid", 32'(pix_valid), 32'd1);
        check("t5_latency_data", 32'(pix_data), 32'h3AB);
        check("t5_latency_sof", 32'(pix_sof), 32'd1);
        check("t5_latency_sol", 32'(pix_sol), 32'd1);
        pclk = 1'b0;
        href = 1'b0;
        step(4);

`ifdef CIS_CROP_EN
        // ---- crop window x0=2 w=4 y0=1 h=2 on a 4x8 frame
        reset_dut();
        q.delete();
        exp_q.delete();
        crop_x0   = 12'd2;
        crop_w    = 12'd4;
        crop_y0   = 12'd1;
        crop_h    = 12'd2;
        pix_ready = 1'b1;
        enable    = 1'b1;
        vsync_pulse();
        send_frame(32'h100);
        vsync_pulse();
        step(8);
        for (int y = 1; y < 3; y++)
            for (int x = 2; x < 6; x++)
                exp_q.push_back(mk((y == 1) && (x == 2), x == 2, 32'h100 + 8 * y + x));
        check_stream("t6_crop");
        check("t6_line_len_uncropped", 32'(line_len), 32'd8);
        check("t6_frame_cnt", 32'(frame_cnt), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cis_dvp_capture.md
# cis_dvp_capture

Parametrised parallel camera (CIS/DVP) capture front end for the ISP user project. It oversamples the sensor PICLK/HSYNC/VSYNC/D[n:0] pins in the `wb_clk_i` domain and tracks frame and line boundaries. Captured pixels go through a small FIFO to a valid/ready pixel stream, tagged with start-of-frame and start-of-line. Next generation of the fixed 10-bit CIS pin hookup: configurable pixel width and FIFO depth, line/frame counting, overflow recovery and an optional crop window.

## Interface
Parameters:
- `DATA_W`, 10, sensor data width (8..12)
- `FIFO_DEPTH`, 16, pixel FIFO entries (power of 2, ≥4)
- `CNT_W`, 12, width of column/row/length counters

Ports:
- `wb_clk_i` in 1: single clock; must be ≥3× PICLK
- `wb_rst_i` in 1: synchronous, active-high reset
- `cis_pclk_i` in 1: sensor pixel clock (asynchronous pin, sampled)
- `cis_href_i` in 1: HSYNC/HREF, high during active line
- `cis_vsync_i` in 1: VSYNC, high pulse between frames
- `cis_data_i` in DATA_W: pixel data
- `enable_i` in 1: capture enable
- `ovf_clr_i` in 1: clears `ovf_o`
- `pix_valid_o` out 1, `pix_ready_i` in 1: output stream handshake
- `pix_data_o` out DATA_W, `pix_sof_o` out 1, `pix_sol_o` out 1: pixel plus tags
- `line_len_o` out CNT_W: pixels in last completed line
- `frame_cnt_o` out 16: completed frames, wraps
- `frame_done_o` out 1: one-cycle pulse at frame end
- `ovf_o` out 1: sticky FIFO-overflow flag
- `busy_o` out 1: state ≠ IDLE

## Operation
- Input sync: all `cis_*` pins pass through 2 flops (s1, s2), plus a history flop s3. PCLK rise = `pclk_s2 & ~pclk_s3`. VSYNC rise and HREF fall use the same scheme.
- Capture: on a PCLK rise with synced HREF=1, sample synced data.
- States:
  - IDLE: `enable_i`=1 → SYNC.
  - SYNC: VSYNC rise → FRAME, x=y=0, sof_pending=1. `enable_i`=0 → IDLE.
  - FRAME: capture pixels. HREF fall → y++, latch `line_len_o`=x, x=0. VSYNC rise → `frame_cnt_o`++, `frame_done_o` pulse, sof_pending=1, y=0. Then stay in FRAME if enabled, else go to IDLE.
  - DROP: discard everything until VSYNC rise. That rise does not count a frame, and gives the same transition as in FRAME.
- Pixel write: {sof, sol, data} goes to the FIFO when captured and inside the window.
  - sof = first written pixel of the frame.
  - sol = first written pixel of each line.
- Overflow: write while FIFO full → pixel dropped, `ovf_o`=1, state → DROP. Already-queued pixels still drain.
- `ovf_clr_i` clears `ovf_o`. If clear and a new overflow happen in the same cycle, set wins.
- Counters x, y and `line_len_o` saturate at 2^CNT_W−1. `frame_cnt_o` wraps.
- Disabling mid-frame completes the frame. Disabling in SYNC goes to IDLE at once.
- `wb_rst_i` mid-frame: empties the FIFO, clears all state, goes to IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty.
- Latency: raw PCLK rise → FIFO write is 3 cycles. FIFO write → `pix_valid_o` is 1 cycle when the FIFO is empty. Total pin-to-stream latency is 4 cycles.
- Stream: transfer when `pix_valid_o & pix_ready_i`. Once `pix_valid_o` is asserted, it and data/tags hold stable until accepted. Full throughput is one pixel per cycle.
- Simultaneous FIFO read and write when full: the write succeeds and there is no overflow.
- `frame_done_o` asserts the cycle after the VSYNC rise is detected.

## Configuration
- `CIS_CROP_EN`:
  - Defined: adds inputs `crop_x0_i`, `crop_y0_i`, `crop_w_i`, `crop_h_i` (CNT_W each), sampled at each VSYNC rise. A pixel is written only if x0 ≤ x < x0+w and y0 ≤ y < y0+h. sof/sol refer to the first written pixel. `line_len_o` still reports the full uncropped line.
  - Not defined: ports absent, every active pixel written.

## Test plan
- Reset, enable, 2 frames of 4 lines × 8 pixels, pclk = wb_clk/4, ready=1 → 64 pixels out with `pix_data_o` matching. sof on pixels 0 and 32; sol every 8th pixel; `line_len_o`=8; `frame_cnt_o`=2; two `frame_done_o` pulses.
- Same stimulus, ready=0 during frame 1, FIFO_DEPTH=16 → first 16 pixels kept, `ovf_o`=1, rest of frame dropped. Frame 2 (32 pixels) is clean after the queue drains. `frame_cnt_o`=1.
- `ovf_clr_i` pulse with no new overflow → `ovf_o`=0 the next cycle.
- Deassert `enable_i` mid-frame 1 → frame 1 completes, `busy_o`=0 after the VSYNC rise, frame 2 ignored.
- `wb_rst_i` pulse mid-line → all outputs 0 next cycle, FIFO empty, no stray output until next enable + VSYNC.
- `CIS_CROP_EN`, crop x0=2, w=4, y0=1, h=2 on a 4×8 frame → 8 pixels: first has sof+sol, 5th has sol.
